// File: rtl/modmul_arbiter.sv
// Round-robin arbiter/sequencer sharing one modmul among N requesters.
// Define MODMUL_ARB_WDOG_EN to enable the WAIT-state watchdog (err/DRAIN path).
module modmul_arbiter #(
  parameter int W       = 2048,
  parameter int N       = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  input  logic [N*W-1:0] req_n,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic [W-1:0]   result,
  output logic           err,
  output logic           busy,
  output logic           mm_start,
  input  logic           mm_ready,
  output logic [W-1:0]   mm_a,
  output logic [W-1:0]   mm_b,
  output logic [W-1:0]   mm_n,
  input  logic [W-1:0]   mm_p
);

  localparam int PW = $clog2(N);
  localparam logic [N-1:0] ONE = N'(1);

  if (N < 2 || N > 16 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
    $error("modmul_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   ptr, winner, pick, idx, ptr_inc;
  logic            found, load, start_nx, wd_hit;
  logic [N-1:0]    gnt_nx, done_nx;
  logic [W-1:0]    result_nx;

  // Search upward from ptr, wrapping after N-1; first set req bit wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i >= N) ? PW'(int'(ptr) + i - N) : PW'(int'(ptr) + i);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign ptr_inc = (pick == PW'(N - 1)) ? '0 : pick + PW'(1);

  always_comb begin
    state_nx  = state;
    gnt_nx    = '0;
    done_nx   = '0;
    start_nx  = 1'b0;
    result_nx = result;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nx = ISSUE;
          gnt_nx   = ONE << pick;
          start_nx = 1'b1;
          load     = 1'b1;
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (mm_ready) begin
          result_nx = mm_p;
          done_nx   = ONE << winner;
          state_nx  = IDLE;
        end else if (wd_hit) begin
          result_nx = '0;
          done_nx   = ONE << winner;
          state_nx  = DRAIN;
        end
      end
      DRAIN: begin
        if (mm_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      winner   <= '0;
      gnt      <= '0;
      done     <= '0;
      busy     <= 1'b0;
      mm_start <= 1'b0;
      result   <= '0;
      mm_a     <= '0;
      mm_b     <= '0;
      mm_n     <= '0;
    end else begin
      state    <= state_nx;
      gnt      <= gnt_nx;
      done     <= done_nx;
      busy     <= (state_nx != IDLE);
      mm_start <= start_nx;
      result   <= result_nx;
      if (load) begin
        ptr    <= ptr_inc;
        winner <= pick;
        mm_a   <= req_a[pick*W +: W];
        mm_b   <= req_b[pick*W +: W];
        mm_n   <= req_n[pick*W +: W];
      end
    end
  end

`ifdef MODMUL_ARB_WDOG_EN
  // Down-counter loaded in ISSUE so expiry lands after TIMEOUT cycles in WAIT.
  localparam logic [15:0] WD_LOAD = 16'(TIMEOUT - 1);
  logic [15:0] wd_cnt;

  assign wd_hit = (wd_cnt == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      err <= (state == WAIT) && !mm_ready && wd_hit;
      if (state == ISSUE)
        wd_cnt <= WD_LOAD;
      else if (state == WAIT && !wd_hit)
        wd_cnt <= wd_cnt - 16'd1;
    end
  end
`else
  assign wd_hit = 1'b0;
  assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_modmul_arbiter.sv
// Directed, table-driven bench for modmul_arbiter with a latency-programmable
// multiplier stand-in; watchdog checks only in MODMUL_ARB_WDOG_EN builds.
module tb_modmul_arbiter;
  localparam int W = 16;
  localparam int N = 4;

  logic           clk, rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_a, req_b, req_n;
  logic [N-1:0]   gnt, done;
  logic [W-1:0]   result, mm_a, mm_b, mm_n, mm_p;
  logic           err, busy, mm_start, mm_ready;

  modmul_arbiter #(.W(W), .N(N), .TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b), .req_n(req_n),
    .gnt(gnt), .done(done), .result(result), .err(err), .busy(busy),
    .mm_start(mm_start), .mm_ready(mm_ready), .mm_a(mm_a), .mm_b(mm_b),
    .mm_n(mm_n), .mm_p(mm_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // multiplier stand-in: ready drops for lat cycles after each start
  int         lat;
  logic [7:0] mm_cnt;
  logic       force_en, force_val;
  always @(posedge clk) begin
    if (rst)               mm_cnt <= 8'd0;
    else if (mm_start)     mm_cnt <= 8'(lat);
    else if (mm_cnt != 0)  mm_cnt <= mm_cnt - 8'd1;
  end
  assign mm_ready = force_en ? force_val : (mm_cnt == 8'd0);
  assign mm_p = (mm_n == '0) ? '0 : W'((32'(mm_a) * 32'(mm_b)) % 32'(mm_n));

  logic [W-1:0] op_a [N], op_b [N], op_n [N];
  int total, bad;

  typedef struct {
    logic [N-1:0] r;
    logic [N-1:0] g;
    logic [W-1:0] res;
    int           l;
  } vec_t;
  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    req = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_op(input logic [N-1:0] r, input logic [N-1:0] eg,
                        input logic [W-1:0] er, input int l, input string tag);
    int w, cyc;
    logic seen;
    w = 0;
    for (int i = 0; i < N; i++) if (eg[i]) w = i;
    lat = l;
    req = r;
    @(negedge clk);
    chk({tag, " gnt"}, 64'(gnt), 64'(eg));
    chk({tag, " start"}, 64'(mm_start), 64'd1);
    chk({tag, " busy"}, 64'(busy), 64'd1);
    chk({tag, " mm_a"}, 64'(mm_a), 64'(op_a[w]));
    chk({tag, " mm_b"}, 64'(mm_b), 64'(op_b[w]));
    chk({tag, " mm_n"}, 64'(mm_n), 64'(op_n[w]));
    cyc = 1;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done != '0) seen = 1'b1;
      chk({tag, " gnt idle"}, 64'(gnt), 64'd0);
      chk({tag, " mm_a hold"}, 64'(mm_a), 64'(op_a[w]));
    end
    chk({tag, " done"}, 64'(done), 64'(eg));
    chk({tag, " result"}, 64'(result), 64'(er));
    chk({tag, " err"}, 64'(err), 64'd0);
    chk({tag, " latency"}, 64'(cyc), 64'(l + 3));
  endtask

  initial begin
    int cyc;
    total = 0; bad = 0;
    force_en = 1'b0; force_val = 1'b0; lat = 0;
    op_a[0] = 16'd3;   op_b[0] = 16'd5;   op_n[0] = 16'd7;    // -> 1
    op_a[1] = 16'd10;  op_b[1] = 16'd12;  op_n[1] = 16'd13;   // -> 3
    op_a[2] = 16'd100; op_b[2] = 16'd200; op_n[2] = 16'd257;  // -> 211
    op_a[3] = 16'd9;   op_b[3] = 16'd9;   op_n[3] = 16'd11;   // -> 4
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = op_a[i];
      req_b[i*W +: W] = op_b[i];
      req_n[i*W +: W] = op_n[i];
    end
    vecs[0] = '{4'b1111, 4'b0001, 16'd1,   2};
    vecs[1] = '{4'b1111, 4'b0010, 16'd3,   0};
    vecs[2] = '{4'b1111, 4'b0100, 16'd211, 5};
    vecs[3] = '{4'b1111, 4'b1000, 16'd4,   1};
    vecs[4] = '{4'b1111, 4'b0001, 16'd1,   3};
    vecs[5] = '{4'b1111, 4'b0010, 16'd3,   4};
    vecs[6] = '{4'b1010, 4'b1000, 16'd4,   2};
    vecs[7] = '{4'b1010, 4'b0010, 16'd3,   1};
    vecs[8] = '{4'b1010, 4'b1000, 16'd4,   6};

    apply_reset();
    chk("rst gnt", 64'(gnt), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst err", 64'(err), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst start", 64'(mm_start), 64'd0);
    chk("rst result", 64'(result), 64'd0);
    chk("rst mm_a", 64'(mm_a), 64'd0);
    chk("rst mm_b", 64'(mm_b), 64'd0);
    chk("rst mm_n", 64'(mm_n), 64'd0);

    run_op(4'b0001, 4'b0001, 16'd1, 10, "single");

    apply_reset();
    for (int i = 0; i < 9; i++)
      run_op(vecs[i].r, vecs[i].g, vecs[i].res, vecs[i].l, $sformatf("vec%0d", i));

    // reset while waiting on the multiplier
    req = '0;
    repeat (2) @(negedge clk);
    lat = 10;
    req = 4'b0100;
    @(negedge clk);
    chk("abort gnt", 64'(gnt), 64'b0100);
    req = '0;
    repeat (3) @(negedge clk);
    chk("abort busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort gnt0", 64'(gnt), 64'd0);
    chk("abort busy0", 64'(busy), 64'd0);
    chk("abort start0", 64'(mm_start), 64'd0);
    chk("abort result0", 64'(result), 64'd0);
    chk("abort mm_a0", 64'(mm_a), 64'd0);
    chk("abort mm_n0", 64'(mm_n), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      chk("abort no done", 64'(done), 64'd0);
    end
    run_op(4'b1010, 4'b0010, 16'd3, 2, "ptr after rst");
    run_op(4'b0100, 4'b0100, 16'd211, 3, "after abort");

    // ready high during ISSUE must be ignored
    req = 4'b0001; lat = 0;
    force_en = 1'b1; force_val = 1'b1;
    @(negedge clk);
    chk("issue gnt", 64'(gnt), 64'b0001);
    req = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      force_val = 1'b0;
      chk("issue early done", 64'(done), 64'd0);
      chk("issue mm_a", 64'(mm_a), 64'd3);
      chk("issue mm_b", 64'(mm_b), 64'd5);
      chk("issue mm_n", 64'(mm_n), 64'd7);
    end
    @(negedge clk);
    force_val = 1'b1;
    chk("issue early done", 64'(done), 64'd0);
    @(negedge clk);
    chk("issue done", 64'(done), 64'b0001);
    chk("issue result", 64'(result), 64'd1);
    force_en = 1'b0;
    @(negedge clk);

`ifdef MODMUL_ARB_WDOG_EN
    force_en = 1'b1; force_val = 1'b0; lat = 1;
    req = 4'b1000;
    @(negedge clk);
    chk("wd gnt", 64'(gnt), 64'b1000);
    req = '0;
    cyc = 0;
    while (done == '0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("wd done", 64'(done), 64'b1000);
    chk("wd err", 64'(err), 64'd1);
    chk("wd result", 64'(result), 64'd0);
    chk("wd drain busy", 64'(busy), 64'd1);
    req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("wd drain gnt", 64'(gnt), 64'd0);
    end
    force_val = 1'b1;
    @(negedge clk);
    chk("wd drain exit", 64'(busy), 64'd0);
    @(negedge clk);
    chk("wd regrant", 64'(gnt), 64'b0001);
    req = '0;
    force_en = 1'b0;
    cyc = 0;
    while (done == '0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("wd next done", 64'(done), 64'b0001);
    chk("wd next err", 64'(err), 64'd0);
    chk("wd next result", 64'(result), 64'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
